seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, default 4, consecutive identical-sample cycles required before capture (legal 2..15).
REQ-002 SHALL have ports, one per line:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- seg_in  input  7  segment lines {a,b,c,d,e,f,g}, a = bit 6, active-high.
- dp_in  input  1  decimal-point line, active-high.
- dig_sel  input  2  digit currently driven on the bus (0..3).
- dig_en  input  1  bus-driving strobe; 0 = bus blanked.
- digits  output  16  captured BCD, digit n at bits [4n+3:4n].
- valid  output  4  valid[n] = digit n holds a decoded value.
- dp_out  output  4  captured decimal point per digit.
- frame_done  output  1  one-cycle pulse, full ordered 0-1-2-3 scan captured.
- err  output  1  one-cycle pulse, undecodable pattern captured.
REQ-003 SHALL use one clock (clk) and an asynchronous active-low reset (rst_n), per the already-decided interface.

Function
REQ-004 SHALL compare the sample tuple {seg_in, dp_in, dig_sel} each cycle against the previous cycle's registered tuple.
REQ-005 SHALL implement states: IDLE (dig_en=0), SETTLE (counting), HELD (captured, waiting for change).
REQ-006 SHALL transition as follows:
- IDLE->SETTLE when dig_en=1, with the counter loaded to 1.
- SETTLE: counter increments while the tuple is unchanged and dig_en=1; a tuple change reloads it to 1.
- SETTLE->HELD on the edge at which the counter reaches STABLE_CYCLES (capture edge).
- HELD->SETTLE on a tuple change, with the counter loaded to 1.
- any state->IDLE when dig_en=0, counter cleared.
REQ-007 SHALL perform exactly one capture per stable dwell; no recapture in HELD.
REQ-008 SHALL decode patterns as follows: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex, a = MSB).
REQ-009 SHALL, on a capture edge with a legal pattern, write digits[dig_sel] and set valid[dig_sel]=1.
REQ-010 SHALL, on a capture edge with an illegal pattern (including 00), leave digits[dig_sel] unchanged, clear valid[dig_sel], and pulse err for one cycle.
REQ-011 SHALL track frame order with an expect pointer:
- A capture of digit == expect advances the pointer.
- Any other capture sets expect = 1 if the captured digit is 0, else 0.
- A capture of digit 3 while expect = 3 pulses frame_done for one cycle and sets expect = 0.
REQ-012 SHALL count illegal-pattern captures as in-order captures for the frame-order pointer.
REQ-013 SHALL register all outputs; capture results are visible in the cycle after the capture edge.
REQ-014 SHALL, when dig_en falls mid-SETTLE, discard the dwell: no capture, no pulse.

Reset
REQ-015 SHALL, while rst_n=0, asynchronously force: digits=0000, valid=0, dp_out=0, frame_done=0, err=0, state=IDLE, counter=0, expect=0, sample register=0.
REQ-016 SHALL, when reset asserts mid-SETTLE, produce no capture after release; counting restarts from IDLE.

Configuration
REQ-017 SHALL, when SEG7_DP_CAPTURE_EN is defined, store dp_in into dp_out[dig_sel] on every capture edge (legal or illegal) and include dp_in in the stability compare.
REQ-018 SHALL, when SEG7_DP_CAPTURE_EN is undefined, tie dp_out to 0000 and ignore dp_in entirely.

Verification
REQ-019 SHALL cover these directed scenarios:
- Scan 0:7E, 1:30, 2:6D, 3:79 held for 4 cycles each -> digits=3210 (hex), valid=F, one frame_done pulse after digit 3.
- Digit 1 pattern 30 held for 3 cycles then changed -> no capture, valid[1] unchanged.
- Digit 2 pattern 0x55 held for 4 cycles -> err pulse, valid[2]=0, digits[11:8] retained.
- Order 0,2,3 -> no frame_done; then 0,1,2,3 -> exactly one frame_done.
- rst_n low for 1 cycle during SETTLE of digit 0 -> all outputs 0, no capture after release.
- With the macro defined, digit 1 with dp_in=1 -> dp_out=0010; without the macro, dp_out stays 0000.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, captures each digit after a stable dwell and
// decodes it to BCD. Define SEG7_DP_CAPTURE_EN to also capture the decimal points.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic        dp_in,
  input  logic [1:0]  dig_sel,
  input  logic        dig_en,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic [3:0]  dp_out,
  output logic        frame_done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HELD = 2'd2} state_t;

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [9:0]      tuple, smp_q;
  logic            chg, cap;
  logic            legal;
  logic [3:0]      bcd;
  logic [3:0][3:0] dig_q;
  logic [1:0]      exp_q;

`ifdef SEG7_DP_CAPTURE_EN
  assign tuple = {seg_in, dp_in, dig_sel};
`else
  // dp_in is left out of the stability compare entirely
  logic unused_dp;
  assign unused_dp = dp_in;
  assign tuple     = {seg_in, 1'b0, dig_sel};
`endif

  assign chg    = (tuple != smp_q);
  assign digits = dig_q;

  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (seg_in)
      7'h7E: bcd = 4'd0;
      7'h30: bcd = 4'd1;
      7'h6D: bcd = 4'd2;
      7'h79: bcd = 4'd3;
      7'h33: bcd = 4'd4;
      7'h5B: bcd = 4'd5;
      7'h5F: bcd = 4'd6;
      7'h70: bcd = 4'd7;
      7'h7F: bcd = 4'd8;
      7'h7B: bcd = 4'd9;
      default: legal = 1'b0;
    endcase
  end

  // cap fires on the single edge where the dwell count reaches STABLE_CYCLES
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    if (!dig_en) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = 4'd1;
        end
        SETTLE: begin
          if (chg) begin
            cnt_d = 4'd1;
          end else if (cnt_q + 4'd1 == STABLE_N) begin
            cnt_d   = cnt_q + 4'd1;
            cap     = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        HELD: begin
          if (chg) begin
            state_d = SETTLE;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= tuple;
    end
  end

  // Illegal captures still advance the frame-order pointer like legal ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q      <= '0;
      valid      <= 4'd0;
      exp_q      <= 2'd0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (cap) begin
        if (legal) begin
          dig_q[dig_sel] <= bcd;
          valid[dig_sel] <= 1'b1;
        end else begin
          valid[dig_sel] <= 1'b0;
          err            <= 1'b1;
        end
        if (dig_sel == exp_q) begin
          if (dig_sel == 2'd3) begin
            frame_done <= 1'b1;
            exp_q      <= 2'd0;
          end else begin
            exp_q <= exp_q + 2'd1;
          end
        end else begin
          exp_q <= (dig_sel == 2'd0) ? 2'd1 : 2'd0;
        end
      end
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dp_out          <= 4'd0;
    else if (cap) dp_out[dig_sel] <= dp_in;
  end
`else
  assign dp_out = 4'd0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised + directed bench for seg7_scan_decoder against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int N = 4;
  localparam logic [6:0] TBL [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                      7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_in = '0;
  logic        dp_in = 1'b0;
  logic [1:0]  dig_sel = '0;
  logic        dig_en = 1'b0;
  logic [15:0] digits;
  logic [3:0]  valid, dp_out;
  logic        frame_done, err;

  int tests = 0, fails = 0;
  int fd_cnt = 0, err_cnt = 0;

  seg7_scan_decoder #(.STABLE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dp_in(dp_in), .dig_sel(dig_sel),
    .dig_en(dig_en), .digits(digits), .valid(valid), .dp_out(dp_out),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: a capture happens when a continuous enabled run of one
  // tuple reaches exactly N cycles.
  logic [3:0][3:0] m_dig;
  logic [3:0]      m_val, m_dp;
  logic            m_fd, m_err;
  int              run, mexp;
  logic [9:0]      prev;

  function automatic int dec(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (TBL[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [9:0] tup(input logic [6:0] s, input logic d, input logic [1:0] sel);
`ifdef SEG7_DP_CAPTURE_EN
    return {s, d, sel};
`else
    return {s, 1'b0, sel};
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nr, k, d;
    if (!rst_n) begin
      m_dig <= '0; m_val <= '0; m_dp <= '0; m_fd <= 1'b0; m_err <= 1'b0;
      run <= 0; mexp <= 0; prev <= '0;
    end else begin
      m_fd  <= 1'b0;
      m_err <= 1'b0;
      if (!dig_en) nr = 0;
      else if (run == 0 || tup(seg_in, dp_in, dig_sel) != prev) nr = 1;
      else nr = run + 1;
      run  <= nr;
      prev <= tup(seg_in, dp_in, dig_sel);
      if (nr == N) begin
        d = int'(dig_sel);
        k = dec(seg_in);
        if (k >= 0) begin
          m_dig[dig_sel] <= 4'(k);
          m_val[dig_sel] <= 1'b1;
        end else begin
          m_val[dig_sel] <= 1'b0;
          m_err <= 1'b1;
        end
`ifdef SEG7_DP_CAPTURE_EN
        m_dp[dig_sel] <= dp_in;
`endif
        if (d == mexp) begin
          if (d == 3) begin m_fd <= 1'b1; mexp <= 0; end
          else mexp <= mexp + 1;
        end else begin
          mexp <= (d == 0) ? 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_digits", 32'(digits), 32'(m_dig));
    chk("cyc_valid", 32'(valid), 32'(m_val));
    chk("cyc_dp_out", 32'(dp_out), 32'(m_dp));
    chk("cyc_frame_done", 32'(frame_done), 32'(m_fd));
    chk("cyc_err", 32'(err), 32'(m_err));
  end

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic drive(input int d, input logic [6:0] pat, input logic dp, input logic en, input int n);
    dig_sel = 2'(d); seg_in = pat; dp_in = dp; dig_en = en;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 7'h00, 1'b0, 1'b0, 1);
  endtask

  initial begin
    int fd0, er0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_dp_out", 32'(dp_out), 32'h0);
    chk("reset_pulses", {30'd0, frame_done, err}, 32'h0);
    rst_n = 1'b1;
    idle();

    // ordered scan 0..3
    fd0 = fd_cnt;
    drive(0, 7'h7E, 1'b0, 1'b1, 4);
    drive(1, 7'h30, 1'b0, 1'b1, 4);
    drive(2, 7'h6D, 1'b0, 1'b1, 4);
    drive(3, 7'h79, 1'b0, 1'b1, 4);
    idle();
    chk("scan_digits", 32'(digits), 32'h3210);
    chk("scan_valid", 32'(valid), 32'hF);
    chk("scan_frame_done", 32'(fd_cnt - fd0), 32'd1);
    chk("model_digits", 32'(m_dig), 32'h3210);

    // three-cycle dwell is too short
    drive(1, 7'h30, 1'b0, 1'b1, 3);
    drive(1, 7'h00, 1'b0, 1'b1, 1);
    idle();
    chk("short_valid", 32'(valid), 32'hF);
    chk("short_digits", 32'(digits), 32'h3210);

    // illegal pattern
    er0 = err_cnt;
    drive(2, 7'h55, 1'b0, 1'b1, 4);
    idle();
    chk("illegal_err", 32'(err_cnt - er0), 32'd1);
    chk("illegal_valid", 32'(valid), 32'hB);
    chk("illegal_digit2", 32'(digits[11:8]), 32'h2);

    // out-of-order then in-order frame
    fd0 = fd_cnt;
    drive(0, 7'h7E, 1'b0, 1'b1, 4);
    drive(2, 7'h6D, 1'b0, 1'b1, 4);
    drive(3, 7'h79, 1'b0, 1'b1, 4);
    idle();
    chk("order_023", 32'(fd_cnt - fd0), 32'd0);
    drive(0, 7'h7E, 1'b0, 1'b1, 4);
    drive(1, 7'h30, 1'b0, 1'b1, 4);
    drive(2, 7'h6D, 1'b0, 1'b1, 4);
    drive(3, 7'h79, 1'b0, 1'b1, 4);
    idle();
    chk("order_0123", 32'(fd_cnt - fd0), 32'd1);

    // reset during a dwell
    drive(0, 7'h7E, 1'b0, 1'b1, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 7'h7E, 1'b0, 1'b1, 2);
    idle();
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("model_rst_valid", 32'(m_val), 32'h0);

    // decimal point on digit 1
    drive(1, 7'h30, 1'b1, 1'b1, 4);
    idle();
`ifdef SEG7_DP_CAPTURE_EN
    chk("dp_digit1", 32'(dp_out), 32'h2);
`else
    chk("dp_digit1", 32'(dp_out), 32'h0);
`endif
    chk("dp_valid", 32'(valid), 32'h2);
    chk("dp_digits", 32'(digits), 32'h0010);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [6:0] p;
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      p = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TBL[$urandom_range(0, 9)];
      drive(int'($urandom_range(0, 3)), p, 1'($urandom), ($urandom_range(0, 7) != 0),
            int'($urandom_range(1, 6)));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
